sca_blk_alloc: RTL and testbench



---
 rtl/sca_blk_alloc_pkg.sv | 14 +
 rtl/sca_blk_alloc_fifo.sv | 66 ++++++
 rtl/sca_blk_alloc.sv | 134 +++++++++++++
 tb/tb_sca_blk_alloc.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sca_blk_alloc_pkg.sv
// Shared SCA block-allocation constants and types, used by the write sequencer,
// the digitizer controller and the block allocator.
package sca_blk_alloc_pkg;

    localparam int unsigned SCA_NBLK      = 12;
    localparam int unsigned SCA_AW        = 4;
    localparam int unsigned SCA_AFULL_THR = 2;

    typedef logic [SCA_AW-1:0] blk_addr_t;

    // Block owned by the writer straight out of reset.
    localparam blk_addr_t RESET_BLK = '0;

endpackage

// File: rtl/sca_blk_alloc_fifo.sv
// Readout queue of closed SCA blocks awaiting digitization. The head is held in a
// register so that RD_BLK comes straight from a flop.
module sca_blk_fifo #(
    parameter int unsigned DEPTH = 12,
    parameter int unsigned AW    = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic [AW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] head,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, head_q, head_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        empty_d  = (count_d == '0);
        head_d   = head_q;
        if (count_d == '0) begin
            head_d = '0;
        end else if (pop) begin
            head_d = (count_q > (AW+1)'(1)) ? mem_q[ptr_inc(rd_ptr_q)] : push_data;
        end else if (count_q == '0) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = head_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/sca_blk_alloc.sv
// SCA block allocator: free bitmap with lowest-index allocation, readout queue,
// digitizer ownership and full/overflow status.
module sca_blk_alloc
    import sca_blk_alloc_pkg::*;
#(
    parameter int unsigned NBLK      = SCA_NBLK,
    parameter int unsigned AW        = SCA_AW,
    parameter int unsigned AFULL_THR = SCA_AFULL_THR
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WR_REQ,
    input  logic          WR_KEEP,
    output logic [AW-1:0] CUR_BLK,
    output logic          RD_RDY,
    output logic [AW-1:0] RD_BLK,
    input  logic          RD_ACK,
    input  logic          RD_DONE,
    output logic          DIG_BSY,
    output logic [AW-1:0] DIG_BLK,
    output logic [AW:0]   FREE_CNT,
    output logic          FULL,
    output logic          ALMOST_FULL,
    output logic          ALLOC_ERR,
    output logic [7:0]    OVF_CNT
);

    localparam logic [AW-1:0]   CUR_RST   = AW'(RESET_BLK);
    localparam logic [NBLK-1:0] FREE_RST  = ~(NBLK'(1) << CUR_RST);
    localparam logic [AW:0]     CNT_RST   = (AW+1)'(NBLK - 1);
    localparam logic            AFULL_RST = (NBLK - 1 <= AFULL_THR);

    logic [NBLK-1:0] free_q, free_d;
    logic [AW-1:0]   cur_q, cur_d, dig_blk_q, dig_blk_d, alloc_idx, fifo_head;
    logic [AW:0]     free_cnt_q, free_cnt_d, fifo_count;
    logic [7:0]      ovf_q, ovf_d;
    logic            dig_bsy_q, dig_bsy_d, alloc_err_q, alloc_err_d;
    logic            full_q, full_d, afull_q, afull_d;
    logic            has_free, alloc, wr_ret, fifo_push, done_ok, ack_ok, fifo_empty;

    always_comb begin
        alloc_idx = '0;
        for (int i = NBLK - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_idx = AW'(i);
        end
    end

    always_comb begin
        has_free  = |free_q;
        alloc     = WR_REQ & has_free;
        wr_ret    = alloc & ~WR_KEEP;
        fifo_push = alloc & WR_KEEP;
        done_ok   = RD_DONE & dig_bsy_q;
        ack_ok    = RD_ACK & ~fifo_empty & (~dig_bsy_q | RD_DONE);

        // Selection uses free_q; releases only become allocatable next cycle.
        free_d = free_q;
        if (alloc)   free_d[alloc_idx] = 1'b0;
        if (wr_ret)  free_d[cur_q]     = 1'b1;
        if (done_ok) free_d[dig_blk_q] = 1'b1;

        free_cnt_d = free_cnt_q + (AW+1)'(wr_ret) + (AW+1)'(done_ok) - (AW+1)'(alloc);
        full_d     = (free_cnt_d == '0);
        afull_d    = (free_cnt_d <= (AW+1)'(AFULL_THR));
        cur_d      = alloc ? alloc_idx : cur_q;

        dig_bsy_d = dig_bsy_q;
        dig_blk_d = dig_blk_q;
        if (ack_ok) begin
            dig_bsy_d = 1'b1;
            dig_blk_d = fifo_head;
        end else if (done_ok) begin
            dig_bsy_d = 1'b0;
        end

        alloc_err_d = WR_REQ & ~has_free;
        ovf_d       = (alloc_err_d && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            free_q      <= FREE_RST;
            cur_q       <= CUR_RST;
            free_cnt_q  <= CNT_RST;
            full_q      <= 1'b0;
            afull_q     <= AFULL_RST;
            dig_bsy_q   <= 1'b0;
            dig_blk_q   <= '0;
            alloc_err_q <= 1'b0;
            ovf_q       <= '0;
        end else begin
            free_q      <= free_d;
            cur_q       <= cur_d;
            free_cnt_q  <= free_cnt_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            dig_bsy_q   <= dig_bsy_d;
            dig_blk_q   <= dig_blk_d;
            alloc_err_q <= alloc_err_d;
            ovf_q       <= ovf_d;
        end
    end

    sca_blk_fifo #(
        .DEPTH (NBLK),
        .AW    (AW)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (fifo_push),
        .push_data (cur_q),
        .pop       (ack_ok),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Block addresses are unique, so a push into a full queue means corrupted bookkeeping.
    always_ff @(posedge CLK) begin
        if (!RST) assert (!(fifo_push && !ack_ok && fifo_count == (AW+1)'(NBLK)));
    end

    assign CUR_BLK     = cur_q;
    assign RD_RDY      = ~fifo_empty;
    assign RD_BLK      = fifo_head;
    assign DIG_BSY     = dig_bsy_q;
    assign DIG_BLK     = dig_blk_q;
    assign FREE_CNT    = free_cnt_q;
    assign FULL        = full_q;
    assign ALMOST_FULL = afull_q;
    assign ALLOC_ERR   = alloc_err_q;
    assign OVF_CNT     = ovf_q;

endmodule

// File: tb/tb_sca_blk_alloc.sv
// Bench for sca_blk_alloc: directed scenarios plus randomized traffic, all checked
// against a set/queue-based model of block ownership.
module tb_sca_blk_alloc;

    localparam int NBLK      = 12;
    localparam int AFULL_THR = 2;

    logic       CLK = 1'b0, RST = 1'b1;
    logic       WR_REQ = 1'b0, WR_KEEP = 1'b0, RD_ACK = 1'b0, RD_DONE = 1'b0;
    logic [3:0] CUR_BLK, RD_BLK, DIG_BLK;
    logic [4:0] FREE_CNT;
    logic [7:0] OVF_CNT;
    logic       RD_RDY, DIG_BSY, FULL, ALMOST_FULL, ALLOC_ERR;

    sca_blk_alloc dut (
        .CLK(CLK), .RST(RST), .WR_REQ(WR_REQ), .WR_KEEP(WR_KEEP), .CUR_BLK(CUR_BLK),
        .RD_RDY(RD_RDY), .RD_BLK(RD_BLK), .RD_ACK(RD_ACK), .RD_DONE(RD_DONE),
        .DIG_BSY(DIG_BSY), .DIG_BLK(DIG_BLK), .FREE_CNT(FREE_CNT), .FULL(FULL),
        .ALMOST_FULL(ALMOST_FULL), .ALLOC_ERR(ALLOC_ERR), .OVF_CNT(OVF_CNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: which blocks are free, the readout queue, writer and digitizer ownership.
    bit m_free [NBLK];
    int m_q [$];
    int m_cur, m_dig, m_ovf;
    bit m_bsy, m_err, m_ever_err;

    function automatic int m_free_cnt();
        int c = 0;
        for (int i = 0; i < NBLK; i++) c += int'(m_free[i]);
        return c;
    endfunction

    task automatic m_init();
        for (int i = 0; i < NBLK; i++) m_free[i] = (i != 0);
        m_q.delete();
        m_cur = 0; m_dig = 0; m_ovf = 0;
        m_bsy = 0; m_err = 0; m_ever_err = 0;
    endtask

    task automatic m_step(input bit wr, input bit keep, input bit ack, input bit done);
        int low = -1, popped = 0, rel_wr = -1, rel_dig = -1;
        bit ack_ok, done_ok;
        for (int i = 0; i < NBLK; i++) if (m_free[i] && low < 0) low = i;
        ack_ok  = ack && m_q.size() > 0 && (!m_bsy || done);
        done_ok = done && m_bsy;
        m_err   = 0;
        if (ack_ok) popped = m_q.pop_front();
        if (wr) begin
            if (low >= 0) begin
                m_free[low] = 0;
                if (keep) m_q.push_back(m_cur);
                else rel_wr = m_cur;
                m_cur = low;
            end else begin
                m_err = 1;
                m_ever_err = 1;
                if (m_ovf < 255) m_ovf++;
            end
        end
        if (done_ok) rel_dig = m_dig;
        if (ack_ok) begin
            m_dig = popped;
            m_bsy = 1;
        end else if (done_ok) begin
            m_bsy = 0;
        end
        if (rel_wr >= 0) m_free[rel_wr] = 1;
        if (rel_dig >= 0) m_free[rel_dig] = 1;
    endtask

    // Block addresses on RD_BLK / DIG_BLK only matter while their valid flag is set.
    function automatic logic [29:0] exp_vec();
        int fc  = m_free_cnt();
        bit rdy = m_q.size() > 0;
        return {4'(m_cur), rdy, rdy ? 4'(m_q[0]) : 4'd0, m_bsy, m_bsy ? 4'(m_dig) : 4'd0,
                5'(fc), fc == 0, fc <= AFULL_THR, m_err, 8'(m_ovf)};
    endfunction

    function automatic logic [29:0] dut_vec();
        return {CUR_BLK, RD_RDY, RD_RDY ? RD_BLK : 4'd0, DIG_BSY, DIG_BSY ? DIG_BLK : 4'd0,
                FREE_CNT, FULL, ALMOST_FULL, ALLOC_ERR, OVF_CNT};
    endfunction

    task automatic cyc(input bit wr, input bit keep, input bit ack, input bit done);
        WR_REQ = wr; WR_KEEP = keep; RD_ACK = ack; RD_DONE = done;
        m_step(wr, keep, ack, done);
        @(posedge CLK);
        #1;
        WR_REQ = 0; WR_KEEP = 0; RD_ACK = 0; RD_DONE = 0;
    endtask

    task automatic do_reset();
        WR_REQ = 0; WR_KEEP = 0; RD_ACK = 0; RD_DONE = 0;
        RST = 1;
        m_init();
        @(posedge CLK);
        #1;
        RST = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL reset_state: got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
        n_checks++;
        if ({CUR_BLK, FREE_CNT, RD_RDY, DIG_BSY, FULL, ALMOST_FULL} !== {4'd0, 5'd11, 4'b0000})
            $display("FAIL reset_values: got cur=%0d free=%0d rdy=%b bsy=%b full=%b af=%b, want 0/11/0/0/0/0",
                     CUR_BLK, FREE_CNT, RD_RDY, DIG_BSY, FULL, ALMOST_FULL);
        else n_pass++;
    endtask

    task automatic test_keep_alloc();
        do_reset();
        cyc(1, 1, 0, 0);
        n_checks++;
        if ({CUR_BLK, FREE_CNT, RD_RDY, RD_BLK} !== {4'd1, 5'd10, 1'b1, 4'd0})
            $display("FAIL keep_alloc: got cur=%0d free=%0d rdy=%b rd_blk=%0d, want 1/10/1/0",
                     CUR_BLK, FREE_CNT, RD_RDY, RD_BLK);
        else n_pass++;
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL keep_alloc_vec: got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_discard_reuse();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0, 0);
            n_checks++;
            if (FREE_CNT !== 5'd11 || RD_RDY !== 1'b0)
                $display("FAIL discard_cnt[%0d]: got free=%0d rdy=%b want 11/0", k, FREE_CNT, RD_RDY);
            else n_pass++;
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL discard_vec[%0d]: got %h want %h", k, dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_full_ovf();
        do_reset();
        repeat (11) cyc(1, 1, 0, 0);
        n_checks++;
        if ({FREE_CNT, FULL, ALMOST_FULL, CUR_BLK} !== {5'd0, 1'b1, 1'b1, 4'd11})
            $display("FAIL full_flags: got free=%0d full=%b af=%b cur=%0d want 0/1/1/11",
                     FREE_CNT, FULL, ALMOST_FULL, CUR_BLK);
        else n_pass++;
        cyc(1, 1, 0, 0);
        n_checks++;
        if ({ALLOC_ERR, OVF_CNT, CUR_BLK, FREE_CNT} !== {1'b1, 8'd1, 4'd11, 5'd0})
            $display("FAIL alloc_err: got err=%b ovf=%0d cur=%0d free=%0d want 1/1/11/0",
                     ALLOC_ERR, OVF_CNT, CUR_BLK, FREE_CNT);
        else n_pass++;
        cyc(0, 0, 0, 0);
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL err_pulse_end: got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
        repeat (254) cyc(1, 0, 0, 0);
        n_checks++;
        if (OVF_CNT !== 8'd255) $display("FAIL ovf_255: got %0d want 255", OVF_CNT);
        else n_pass++;
        cyc(1, 1, 0, 0);
        n_checks++;
        if ({ALLOC_ERR, OVF_CNT} !== {1'b1, 8'd255})
            $display("FAIL ovf_saturate: got err=%b ovf=%0d want 1/255", ALLOC_ERR, OVF_CNT);
        else n_pass++;
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL ovf_vec: got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_readout();
        do_reset();
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 1, 0);
        n_checks++;
        if ({DIG_BSY, DIG_BLK, RD_RDY, RD_BLK} !== {1'b1, 4'd0, 1'b1, 4'd1})
            $display("FAIL first_ack: got bsy=%b dig=%0d rdy=%b rd=%0d want 1/0/1/1",
                     DIG_BSY, DIG_BLK, RD_RDY, RD_BLK);
        else n_pass++;
        cyc(0, 0, 1, 0);
        n_checks++;
        if ({DIG_BSY, DIG_BLK, RD_RDY, RD_BLK} !== {1'b1, 4'd0, 1'b1, 4'd1})
            $display("FAIL busy_ack_ignored: got bsy=%b dig=%0d rdy=%b rd=%0d want 1/0/1/1",
                     DIG_BSY, DIG_BLK, RD_RDY, RD_BLK);
        else n_pass++;
        cyc(0, 0, 1, 1);
        n_checks++;
        if ({FREE_CNT, DIG_BSY, DIG_BLK, RD_RDY} !== {5'd10, 1'b1, 4'd1, 1'b0})
            $display("FAIL done_and_ack: got free=%0d bsy=%b dig=%0d rdy=%b want 10/1/1/0",
                     FREE_CNT, DIG_BSY, DIG_BLK, RD_RDY);
        else n_pass++;
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL readout_vec: got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        repeat (10) cyc(1, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 1);
        n_checks++;
        if ({CUR_BLK, FREE_CNT, DIG_BSY} !== {4'd11, 5'd2, 1'b0})
            $display("FAIL same_cycle: got cur=%0d free=%0d bsy=%b want 11/2/0", CUR_BLK, FREE_CNT, DIG_BSY);
        else n_pass++;
        n_checks++;
        if (int'(FREE_CNT) + m_q.size() + int'(DIG_BSY) + 1 != NBLK)
            $display("FAIL same_cycle_invariant: got total=%0d want %0d",
                     int'(FREE_CNT) + m_q.size() + int'(DIG_BSY) + 1, NBLK);
        else n_pass++;
        // Both released blocks are allocatable next cycle, lowest first.
        cyc(1, 0, 0, 0);
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL same_cycle_realloc: got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (6) cyc(1, 1, 0, 0);
        cyc(0, 0, 1, 0);
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL pre_reset_vec: got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
        #2;
        RST = 1;
        m_init();
        #1;
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL async_reset: got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
        @(posedge CLK);
        #1;
        RST = 0;
        cyc(1, 1, 0, 0);
        n_checks++;
        if ({RD_RDY, RD_BLK, CUR_BLK} !== {1'b1, 4'd0, 4'd1})
            $display("FAIL queue_discarded: got rdy=%b rd=%0d cur=%0d want 1/0/1", RD_RDY, RD_BLK, CUR_BLK);
        else n_pass++;
    endtask

    task automatic test_random();
        bit wr, keep, ack, done;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            wr   = $urandom_range(0, 99) < 45;
            keep = $urandom_range(0, 99) < 60;
            ack  = $urandom_range(0, 99) < 50;
            done = $urandom_range(0, 99) < 40;
            cyc(wr, keep, ack, done);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL random[%0d]: got %h want %h", k, dut_vec(), exp_vec());
            else n_pass++;
            if (!m_ever_err) begin
                n_checks++;
                if (int'(FREE_CNT) + m_q.size() + int'(DIG_BSY) + 1 != NBLK)
                    $display("FAIL random_invariant[%0d]: got total=%0d want %0d", k,
                             int'(FREE_CNT) + m_q.size() + int'(DIG_BSY) + 1, NBLK);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_keep_alloc();
        test_discard_reuse();
        test_full_ovf();
        test_readout();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
